// File: rtl/mult_sched_pkg.sv
// Shared types and default sizing for the multiply/descale scheduler.
package mult_sched_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_LAT  = 6;
   localparam int DEF_TAGW = 8;
   localparam int DEF_IDW  = $clog2(DEF_NREQ);

   typedef enum logic {
      DRAIN = 1'b0,
      RUN   = 1'b1
   } sched_state_t;

   // Delay-line entry layout at default sizing; the top re-declares it at its own widths.
   typedef struct packed {
      logic                valid;
      logic [DEF_IDW-1:0]  id;
      logic [DEF_TAGW-1:0] tag;
   } dl_entry_t;

endpackage

// File: rtl/mult_descale_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
   import mult_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]          req,
   input  logic [$clog2(NREQ)-1:0]  ptr,
   output logic [NREQ-1:0]          grant,
   output logic [$clog2(NREQ)-1:0]  grant_id
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = $clog2(NREQ)'(idx);
         end
      end
   end

endmodule

// File: rtl/mult_descale_sched.sv
// Shares one fixed-latency multiply/descale pipeline among NREQ requesters,
// tracking in-flight ops with an id/tag delay line and steering results back.
module mult_descale_sched
   import mult_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int LAT  = DEF_LAT,
   parameter int TAGW = DEF_TAGW
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   input  logic [NREQ*TAGW-1:0] req_tag,
   input  logic [NREQ-1:0]      req_natlog,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 issue_en,
   output logic                 mult_valid,
   output logic [31:0]          mult_a,
   output logic [31:0]          mult_b,
   output logic [TAGW-1:0]      mult_tag,
   output logic                 mult_natlog,
   input  logic                 mult_zvalid,
   input  logic [31:0]          mult_z,
   input  logic [TAGW-1:0]      mult_ztag,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_z,
   output logic [TAGW-1:0]      rsp_tag,
   output logic                 busy,
   output logic                 err
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(LAT + 2);

   typedef struct packed {
      logic            valid;
      logic [IDW-1:0]  id;
      logic [TAGW-1:0] tag;
   } entry_t;

   sched_state_t   state, state_nxt;
   logic [CW-1:0]  drain_cnt, drain_cnt_nxt;
   logic [IDW-1:0] rr_ptr, gnt_id, mult_id;
   logic [NREQ-1:0] arb_grant;
   logic           grant_any;
   entry_t         dl [LAT];
   entry_t         tail;
   logic           dl_any;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .grant    (arb_grant),
      .grant_id (gnt_id)
   );

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      req_ready     = '0;
      case (state)
         DRAIN: begin
            drain_cnt_nxt = drain_cnt - 1'b1;
            if (drain_cnt == CW'(1)) state_nxt = RUN;
         end
         RUN: begin
            if (issue_en) req_ready = arb_grant;
         end
         default: state_nxt = DRAIN;
      endcase
   end

   assign grant_any = |req_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= DRAIN;
         drain_cnt <= CW'(LAT + 1);
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr      <= '0;
         mult_valid  <= 1'b0;
         mult_a      <= '0;
         mult_b      <= '0;
         mult_tag    <= '0;
         mult_natlog <= 1'b0;
         mult_id     <= '0;
      end else begin
         mult_valid <= grant_any;
         if (grant_any) begin
            mult_a      <= req_a[32*int'(gnt_id) +: 32];
            mult_b      <= req_b[32*int'(gnt_id) +: 32];
            mult_tag    <= req_tag[TAGW*int'(gnt_id) +: TAGW];
            mult_natlog <= req_natlog[gnt_id];
            mult_id     <= gnt_id;
            rr_ptr      <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
         end
      end
   end

   // The mult_* register acts as stage 0, so a LAT-deep line lands on the result cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < LAT; i++) dl[i] <= '0;
      end else begin
         dl[0] <= '{valid: mult_valid, id: mult_id, tag: mult_tag};
         for (int unsigned i = 1; i < LAT; i++) dl[i] <= dl[i-1];
      end
   end

   assign tail = dl[LAT-1];

   always_comb begin
      dl_any = mult_valid;
      for (int unsigned i = 0; i < LAT; i++) dl_any = dl_any | dl[i].valid;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_z     <= '0;
         rsp_tag   <= '0;
         err       <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (state == RUN) begin
            if (tail.valid) begin
               if (mult_zvalid && (mult_ztag == tail.tag)) begin
                  rsp_valid[tail.id] <= 1'b1;
                  rsp_z              <= mult_z;
                  rsp_tag            <= mult_ztag;
               end else begin
                  err <= 1'b1;
               end
            end else if (mult_zvalid) begin
               err <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == DRAIN) | dl_any | (|rsp_valid);

endmodule

// File: tb/tb_mult_descale_sched.sv
// Scoreboard bench for mult_descale_sched with a behavioural LAT-cycle pipeline stand-in.
module tb_mult_descale_sched;

   localparam int NREQ = 4;
   localparam int LAT  = 6;
   localparam int TAGW = 8;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*32-1:0]   req_a, req_b;
   logic [NREQ*TAGW-1:0] req_tag;
   logic [NREQ-1:0]      req_natlog;
   logic [NREQ-1:0]      req_ready;
   logic                 issue_en;
   logic                 mult_valid, mult_natlog;
   logic [31:0]          mult_a, mult_b;
   logic [TAGW-1:0]      mult_tag;
   logic                 mult_zvalid;
   logic [31:0]          mult_z;
   logic [TAGW-1:0]      mult_ztag;
   logic [NREQ-1:0]      rsp_valid;
   logic [31:0]          rsp_z;
   logic [TAGW-1:0]      rsp_tag;
   logic                 busy, err;

   always #5 clock = ~clock;

   mult_descale_sched #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .req_natlog(req_natlog), .req_ready(req_ready), .issue_en(issue_en),
      .mult_valid(mult_valid), .mult_a(mult_a), .mult_b(mult_b),
      .mult_tag(mult_tag), .mult_natlog(mult_natlog),
      .mult_zvalid(mult_zvalid), .mult_z(mult_z), .mult_ztag(mult_ztag),
      .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_tag(rsp_tag),
      .busy(busy), .err(err)
   );

   function automatic logic [31:0] model_z(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
      return a + b;
   endfunction

   // Pipeline stand-in: mult_valid at cycle c returns as mult_zvalid at c+LAT.
   logic            pv [LAT] = '{default: 1'b0};
   logic [31:0]     pz [LAT] = '{default: '0};
   logic [TAGW-1:0] pt [LAT] = '{default: '0};
   logic            spur     = 1'b0;
   logic [TAGW-1:0] tag_bias = '0;

   always @(posedge clock) begin
      pv[0] <= mult_valid;
      pz[0] <= model_z(mult_a, mult_b);
      pt[0] <= mult_tag;
      for (int i = 1; i < LAT; i++) begin
         pv[i] <= pv[i-1];
         pz[i] <= pz[i-1];
         pt[i] <= pt[i-1];
      end
   end

   assign mult_zvalid = pv[LAT-1] | spur;
   assign mult_z      = pz[LAT-1];
   assign mult_ztag   = pt[LAT-1] + tag_bias;

   typedef struct {
      int              id;
      logic [31:0]     z;
      logic [TAGW-1:0] tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_ptr  = 0;

   always @(negedge clock) begin
      exp_t e;
      if (reset === 1'b0 && rsp_valid !== '0) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp_valid=%b tag=%h, required no response", rsp_valid, rsp_tag);
         end else begin
            e = sb.pop_front();
            if (rsp_valid !== NREQ'(1 << e.id) || rsp_z !== e.z || rsp_tag !== e.tag) begin
               n_fail++;
               $display("FAIL rsp_match: got valid=%b z=%h tag=%h, required valid=%b z=%h tag=%h",
                        rsp_valid, rsp_z, rsp_tag, NREQ'(1 << e.id), e.z, e.tag);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAGW-1:0] tag, input logic nl);
      req_a[32*i +: 32]     = a;
      req_b[32*i +: 32]     = b;
      req_tag[TAGW*i +: TAGW] = tag;
      req_natlog[i]         = nl;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < 60) begin
         tick();
         n++;
      end
      n_checks++;
      if (n >= 60) begin
         n_fail++;
         $display("FAIL idle_timeout: got %0d pending, busy=%b, required 0 pending and busy=0", sb.size(), busy);
      end
   endtask

   task automatic test_reset();
      int cnt = 0;
      reset = 1'b1; req_valid = '0; issue_en = 1'b1;
      req_a = '0; req_b = '0; req_tag = '0; req_natlog = '0;
      tick(); tick();
      n_checks++;
      if ({mult_valid, mult_natlog, mult_a, mult_b, mult_tag} !== '0) begin
         n_fail++;
         $display("FAIL reset_mult_regs: got v=%b a=%h b=%h tag=%h, required all 0", mult_valid, mult_a, mult_b, mult_tag);
      end
      n_checks++;
      if ({rsp_valid, rsp_z, rsp_tag} !== '0 || req_ready !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp: got rsp_valid=%b z=%h tag=%h ready=%b, required all 0", rsp_valid, rsp_z, rsp_tag, req_ready);
      end
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_status: got err=%b busy=%b, required err=0 busy=1", err, busy);
      end
      reset = 1'b0; exp_ptr = 0; sb.delete();
      while (busy === 1'b1 && cnt < 20) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != LAT + 1) begin
         n_fail++;
         $display("FAIL drain_length: got %0d busy cycles, required %0d", cnt, LAT + 1);
      end
      n_checks++;
      if (busy !== 1'b0 || req_ready !== '0) begin
         n_fail++;
         $display("FAIL idle_after_drain: got busy=%b ready=%b, required busy=0 ready=0000", busy, req_ready);
      end
   endtask

   task automatic test_round_robin();
      int g;
      logic [31:0] a, b;
      logic [TAGW-1:0] t;
      req_valid = '1; issue_en = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== '0) begin
         n_fail++;
         $display("FAIL issue_en_block: got ready=%b, required 0000", req_ready);
      end
      issue_en = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         for (int i = 0; i < NREQ; i++)
            set_req(i, 32'h3F80_0000 + 32'(cyc * 16 + i), 32'h0000_1000 * 32'(i + 1), TAGW'(8'h40 + cyc * 4 + i), 1'b0);
         #1;
         g = cyc % NREQ;
         n_checks++;
         if (req_ready !== NREQ'(1 << g)) begin
            n_fail++;
            $display("FAIL rr_order: cycle %0d got ready=%b, required %b", cyc, req_ready, NREQ'(1 << g));
         end
         a = req_a[32*g +: 32]; b = req_b[32*g +: 32]; t = req_tag[TAGW*g +: TAGW];
         sb.push_back('{g, model_z(a, b), t});
         exp_ptr = (g + 1) % NREQ;
         tick();
      end
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_single();
      req_valid = '0;
      set_req(2, 32'h4000_0000, 32'h4040_0000, 8'h15, 1'b1);
      req_valid[2] = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_grant: got ready=%b, required 0100", req_ready);
      end
      sb.push_back('{2, 32'h40C0_0000, 8'h15});
      exp_ptr = 3;
      tick();
      req_valid = '0;
      n_checks++;
      if (mult_valid !== 1'b1 || mult_a !== 32'h4000_0000 || mult_b !== 32'h4040_0000 ||
          mult_tag !== 8'h15 || mult_natlog !== 1'b1) begin
         n_fail++;
         $display("FAIL single_issue: got v=%b a=%h b=%h tag=%h nl=%b, required 1 40000000 40400000 15 1",
                  mult_valid, mult_a, mult_b, mult_tag, mult_natlog);
      end
      repeat (LAT) tick();
      n_checks++;
      if (rsp_valid !== '0) begin
         n_fail++;
         $display("FAIL single_early: got rsp_valid=%b at t+7, required 0000", rsp_valid);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 4'b0100 || rsp_z !== 32'h40C0_0000 || rsp_tag !== 8'h15) begin
         n_fail++;
         $display("FAIL single_rsp: got valid=%b z=%h tag=%h at t+8, required 0100 40c00000 15", rsp_valid, rsp_z, rsp_tag);
      end
      wait_idle();
   endtask

   task automatic test_tag_mismatch();
      tag_bias = 8'h01;
      set_req(2, 32'h4000_0000, 32'h4040_0000, 8'h15, 1'b0);
      req_valid = 4'b0100;
      #1;
      tick();
      req_valid = '0;
      repeat (LAT) tick();
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL mismatch_early: got err=%b at t+7, required 0", err);
      end
      tick();
      n_checks++;
      if (err !== 1'b1 || rsp_valid !== '0) begin
         n_fail++;
         $display("FAIL mismatch_err: got err=%b rsp_valid=%b, required err=1 rsp_valid=0000", err, rsp_valid);
      end
      tag_bias = '0;
      repeat (5) tick();
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got err=%b, required 1", err);
      end
   endtask

   task automatic test_spurious();
      reset = 1'b1; tick(); reset = 1'b0; exp_ptr = 0;
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_reset_clear: got err=%b, required 0", err);
      end
      wait_idle();
      spur = 1'b1; tick(); spur = 1'b0;
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL spurious_run: got err=%b, required 1", err);
      end
      reset = 1'b1; tick(); reset = 1'b0; exp_ptr = 0;
      spur = 1'b1; tick(); spur = 1'b0;
      tick();
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL spurious_drain: got err=%b, required 0", err);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int cnt = 0;
      for (int i = 0; i < 3; i++) begin
         set_req(i, 32'h4100_0000 + 32'(i), 32'h3F00_0000, TAGW'(8'h70 + i), 1'b0);
         req_valid = NREQ'(1 << i);
         #1;
         n_checks++;
         if (req_ready !== NREQ'(1 << i)) begin
            n_fail++;
            $display("FAIL mid_grant: req %0d got ready=%b, required %b", i, req_ready, NREQ'(1 << i));
         end
         tick();
      end
      req_valid = '0;
      repeat (2) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      exp_ptr = 0;
      set_req(0, 32'h4080_0000, 32'h4000_0000, 8'h99, 1'b0);
      req_valid = 4'b0001;
      #1;
      while (req_ready === '0 && cnt < 30) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != LAT + 1 || req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL first_grant_delay: got %0d cycles ready=%b, required %0d cycles ready=0001", cnt, req_ready, LAT + 1);
      end
      sb.push_back('{0, model_z(32'h4080_0000, 32'h4000_0000), 8'h99});
      exp_ptr = 1;
      tick();
      req_valid = '0;
      wait_idle();
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_err: got err=%b, required 0", err);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_tag_mismatch();
      test_spurious();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_descale_sched.md
# mult_descale_sched

Round-robin scheduler that shares one SpecialMultDescale-based multiply/descale pipeline among NREQ requesters, typically the X, Y and Z descale paths of the HCORDIC core. It issues at most one operand pair per cycle, tracks each in-flight operation in a fixed-latency ID/tag delay line, and steers each returning result to its requester. It checks the returned tag against the expected tag and flags any mismatch. After reset, it drains the pipeline before it accepts new work.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 6, cycles from mult_valid asserted to matching mult_zvalid
- TAGW, 8, instruction tag width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester request
- req_a  in  NREQ*32  operand A (IEEE-754 single), requester i at [32i+31:32i]
- req_b  in  NREQ*32  operand B, same packing
- req_tag  in  NREQ*TAGW  instruction tag
- req_natlog  in  NREQ  natural-log flag, forwarded to pipeline
- req_ready  out  NREQ  one-hot grant, combinational
- issue_en  in  1  global issue enable; low blocks all grants
- mult_valid  out  1  drives pipeline ScaleValid
- mult_a, mult_b  out  32 each  drive ain_Special/bin_Special
- mult_tag  out  TAGW  drives InsTagScaleOut
- mult_natlog  out  1  drives NatLogFlagScaleOut
- mult_zvalid  in  1  result valid from pipeline tail
- mult_z  in  32  result
- mult_ztag  in  TAGW  returned tag
- rsp_valid  out  NREQ  one-hot result strobe
- rsp_z  out  32  result, shared bus
- rsp_tag  out  TAGW  result tag
- busy  out  1  any operation in flight or drain active
- err  out  1  sticky protocol error, cleared only by reset

## Operation
- FSM states: DRAIN and RUN. Reset enters DRAIN.
- DRAIN: load a counter with LAT+1 and decrement it each cycle. Hold req_ready at 0 and suppress err. Discard any mult_zvalid. On count 0, go to RUN.
- RUN: grant goes to the first i with req_valid[i] at or after rr_ptr, wrapping modulo NREQ. Grant only when issue_en=1.
- On a grant to requester g:
  - rr_ptr <= (g+1) mod NREQ.
  - Register operands, tag and natlog onto mult_*.
  - Push {1, g, tag} into the delay line.
- No grant: mult_valid=0, push {0, x, x}. mult_a/b/tag hold their last values.
- Delay line depth is LAT. Its tail aligns with the mult_zvalid cycle.
- Tail valid, mult_zvalid=1 and mult_ztag equal to the tail tag: set rsp_valid[tail id]=1 next cycle and register rsp_z and rsp_tag.
- Tail valid but mult_zvalid=0 or tag differs: set err=1, no rsp_valid.
- mult_zvalid=1 with tail invalid, in RUN: set err=1, result dropped.
- Responses have no backpressure. A requester must accept rsp_valid in the cycle it is asserted.
- busy = (state==DRAIN) | any delay-line valid | any rsp_valid.

## Timing
- Request accepted at cycle t (req_valid & req_ready) gives mult_valid at t+1 and mult_zvalid expected at t+1+LAT.
- rsp_valid follows at t+2+LAT. Total latency is LAT+2.
- Throughput is one issue per cycle. Requesters see a maximum wait of NREQ-1 cycles under full load.
- req_ready depends only on req_valid, rr_ptr, issue_en and state, with no path from req_* data.
- Reset values: req_ready=0, mult_valid=0, mult_a=mult_b=0, mult_tag=0, mult_natlog=0, rsp_valid=0, rsp_z=0, rsp_tag=0, err=0, busy=1, rr_ptr=0, delay line cleared.
- Reset mid-operation: in-flight entries are discarded. Pipeline results arriving during DRAIN are ignored without raising err.
- A requester dropping req_valid while not granted is legal. A grant is never withdrawn within its cycle.
- issue_en falling: takes effect the same cycle. In-flight operations still complete.

## Structure
- Package mult_sched_pkg holds:
  - default NREQ, LAT and TAGW;
  - state enum {DRAIN, RUN};
  - delay-line entry struct {valid, id[$clog2(NREQ)-1:0], tag}.
- Sub-module rr_arbiter (NREQ) holds the combinational one-hot grant from req and ptr.
- The rr_ptr register lives in the parent.

## Test plan
- Reset, then idle: busy=1 for 7 cycles (LAT=6), then busy=0 and req_ready=0 with no requests.
- Single request: requester 2 sends a=0x40000000, b=0x40400000, tag=0x15 at t. Require mult_valid at t+1. The model pipeline returns z=0x40C00000, tag 0x15, at t+7. Require rsp_valid=4'b0100, rsp_z=0x40C00000, rsp_tag=0x15 at t+8.
- All four valid continuously for 8 cycles from rr_ptr=0: grant order 0,1,2,3,0,1,2,3. Each response returns to the matching requester, one per cycle.
- Tag mismatch: the pipeline returns tag 0x16 where 0x15 is expected. Require err=1, held until reset, and no rsp_valid.
- Spurious mult_zvalid in RUN with an empty delay line: require err=1. The same stimulus during DRAIN: require err=0.
- Reset asserted 3 cycles after issuing 3 requests: no rsp_valid ever appears for them, err=0, and the first grant occurs 7 cycles after reset deasserts.
